cluster_sequencer: RTL

CLUSTER_SEQUENCER -- requirements
Module: cluster_sequencer

---
 rtl/eyeriss_pkg.sv | 25 ++
 rtl/stream_tag_forwarder.sv | 59 +++++
 rtl/cluster_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/eyeriss_pkg.sv
// rtl/eyeriss_pkg.sv - shared types and constants for the cluster sequencer
package eyeriss_pkg;

  // Sequencer phases, in job order
  typedef enum logic [3:0] {
    S_IDLE,
    S_ID_FILL,
    S_ID_SHIFT,
    S_ID_LATCH,
    S_LOAD_W,
    S_LOAD_A,
    S_START,
    S_COMPUTE,
    S_DONE
  } state_t;

  // Idle tags are all-ones; replicate this bit to the tag width
  localparam logic IDLE_TAG_BIT = 1'b1;

  // One ID slot per PE plus one per row
  function automatic int calc_num_ids(input int pe_x, input int pe_y);
    return pe_x * pe_y + pe_y;
  endfunction

endpackage

// File: rtl/stream_tag_forwarder.sv
// rtl/stream_tag_forwarder.sv - counted stream to cluster bus forwarder with idle tagging
module stream_tag_forwarder
  import eyeriss_pkg::*;
#(
  parameter int dataSize = 8,
  parameter int idSize   = 8,
  parameter int addrSize = 16
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                en_i,
  input  logic [addrSize-1:0] num_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [dataSize-1:0] data_i,
  input  logic [idSize-1:0]   tag_x_i,
  input  logic [idSize-1:0]   tag_y_i,
  output logic [dataSize-1:0] data_o,
  output logic [idSize-1:0]   tag_x_o,
  output logic [idSize-1:0]   tag_y_o,
  output logic                last_o
);

  logic [addrSize-1:0] r_cnt;
  logic                w_accept;

  // Ready follows the phase enable, so it drops the cycle after the final beat
  assign ready_o  = en_i;
  assign w_accept = en_i & valid_i;
  assign last_o   = w_accept && (r_cnt == (num_i - addrSize'(1)));

  // Count accepted beats within the phase; restart whenever the phase is inactive
  always_ff @(posedge clk) begin
    if (nrst) begin
      r_cnt <= '0;
    end else if (!en_i) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + addrSize'(1);
    end
  end

  // Register accepted beats onto the cluster bus; idle tag in every other cycle
  always_ff @(posedge clk) begin
    if (nrst) begin
      data_o  <= '0;
      tag_x_o <= {idSize{IDLE_TAG_BIT}};
      tag_y_o <= {idSize{IDLE_TAG_BIT}};
    end else if (w_accept) begin
      data_o  <= data_i;
      tag_x_o <= tag_x_i;
      tag_y_o <= tag_y_i;
    end else begin
      tag_x_o <= {idSize{IDLE_TAG_BIT}};
      tag_y_o <= {idSize{IDLE_TAG_BIT}};
    end
  end

endmodule

// File: rtl/cluster_sequencer.sv
// rtl/cluster_sequencer.sv - job sequencer: ID scan-in, operand forwarding, compute handshake
module cluster_sequencer
  import eyeriss_pkg::*;
#(
  parameter int numPeX   = 14,
  parameter int numPeY   = 3,
  parameter int dataSize = 8,
  parameter int idSize   = 8,
  parameter int addrSize = 16
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                start_i,
  input  logic [7:0]          cfg_wcount_i,
  input  logic [7:0]          cfg_acount_i,
  input  logic [addrSize-1:0] cfg_num_w_i,
  input  logic [addrSize-1:0] cfg_num_a_i,
  input  logic                id_valid_i,
  output logic                id_ready_o,
  input  logic [idSize-1:0]   act_id_i,
  input  logic [idSize-1:0]   weight_id_i,
  input  logic                w_valid_i,
  output logic                w_ready_o,
  input  logic [dataSize-1:0] w_data_i,
  input  logic [idSize-1:0]   w_tag_x_i,
  input  logic [idSize-1:0]   w_tag_y_i,
  input  logic                a_valid_i,
  output logic                a_ready_o,
  input  logic [dataSize-1:0] a_data_i,
  input  logic [idSize-1:0]   a_tag_x_i,
  input  logic [idSize-1:0]   a_tag_y_i,
  output logic [idSize-1:0]   act_id_scan_o,
  output logic [idSize-1:0]   weight_id_scan_o,
  output logic                act_id_wren_o,
  output logic                weight_id_wren_o,
  output logic [dataSize-1:0] w_data_o,
  output logic [dataSize-1:0] a_data_o,
  output logic [idSize-1:0]   w_tag_x_o,
  output logic [idSize-1:0]   w_tag_y_o,
  output logic [idSize-1:0]   a_tag_x_o,
  output logic [idSize-1:0]   a_tag_y_o,
  output logic                cluster_enable_o,
  output logic                start_compute_o,
  output logic [7:0]          ctrl_wcount_o,
  output logic [7:0]          ctrl_acount_o,
  input  logic                cluster_done_i,
  input  logic                outs_valid_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  localparam int numIds   = calc_num_ids(numPeX, numPeY);
  localparam int ID_CNT_W = $clog2(numIds);
  localparam logic [ID_CNT_W-1:0] ID_LAST = ID_CNT_W'(numIds - 1);

  state_t r_state, w_next_state;

  logic [addrSize-1:0] r_num_w, r_num_a;
  logic [ID_CNT_W-1:0] r_fill_cnt, r_shift_cnt;
  logic [idSize-1:0]   r_act_buf [numIds];
  logic [idSize-1:0]   r_wt_buf  [numIds];
  logic [addrSize-1:0] r_out_cnt;
  logic                r_done_seen;
  logic                r_err;

  logic                w_cfg_ok, w_accept_start;
  logic                w_w_last, w_a_last;
  logic [addrSize-1:0] w_target, w_out_cnt_nxt;
  logic                w_done_seen_nxt;

  assign w_cfg_ok        = (cfg_wcount_i <= cfg_acount_i) && (cfg_wcount_i != 8'd0);
  assign w_accept_start  = (r_state == S_IDLE) && start_i && w_cfg_ok;
  assign w_target        = addrSize'(ctrl_acount_o) - addrSize'(ctrl_wcount_o) + addrSize'(1);
  assign w_out_cnt_nxt   = r_out_cnt + addrSize'(outs_valid_i);
  assign w_done_seen_nxt = r_done_seen | cluster_done_i;
  assign err_o           = r_err;

  // State register
  always_ff @(posedge clk) begin
    if (nrst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state decode and state-derived outputs
  always_comb begin
    w_next_state     = r_state;
    id_ready_o       = 1'b0;
    act_id_wren_o    = 1'b0;
    weight_id_wren_o = 1'b0;
    act_id_scan_o    = '0;
    weight_id_scan_o = '0;
    start_compute_o  = 1'b0;
    done_o           = 1'b0;
    busy_o           = (r_state != S_IDLE);
    cluster_enable_o = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_accept_start) w_next_state = S_ID_FILL;
      end
      S_ID_FILL: begin
        id_ready_o = 1'b1;
        if (id_valid_i && (r_fill_cnt == ID_LAST)) w_next_state = S_ID_SHIFT;
      end
      S_ID_SHIFT: begin
        act_id_scan_o    = r_act_buf[r_shift_cnt];
        weight_id_scan_o = r_wt_buf[r_shift_cnt];
        if (r_shift_cnt == ID_LAST) w_next_state = S_ID_LATCH;
      end
      S_ID_LATCH: begin
        act_id_wren_o    = 1'b1;
        weight_id_wren_o = 1'b1;
        if (r_num_w != '0)      w_next_state = S_LOAD_W;
        else if (r_num_a != '0) w_next_state = S_LOAD_A;
        else                    w_next_state = S_START;
      end
      S_LOAD_W: begin
        if (w_w_last) w_next_state = (r_num_a != '0) ? S_LOAD_A : S_START;
      end
      S_LOAD_A: begin
        if (w_a_last) w_next_state = S_START;
      end
      S_START: begin
        start_compute_o = 1'b1;
        w_next_state    = S_COMPUTE;
      end
      S_COMPUTE: begin
        if ((w_out_cnt_nxt >= w_target) && w_done_seen_nxt) w_next_state = S_DONE;
      end
      S_DONE: begin
        done_o       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Latch job configuration on an accepted start; held until the next one
  always_ff @(posedge clk) begin
    if (nrst) begin
      ctrl_wcount_o <= '0;
      ctrl_acount_o <= '0;
      r_num_w       <= '0;
      r_num_a       <= '0;
    end else if (w_accept_start) begin
      ctrl_wcount_o <= cfg_wcount_i;
      ctrl_acount_o <= cfg_acount_i;
      r_num_w       <= cfg_num_w_i;
      r_num_a       <= cfg_num_a_i;
    end
  end

  // Rejected start yields a one-cycle error pulse
  always_ff @(posedge clk) begin
    if (nrst) r_err <= 1'b0;
    else      r_err <= (r_state == S_IDLE) && start_i && !w_cfg_ok;
  end

  // ID fill buffer and its write / scan indices
  always_ff @(posedge clk) begin
    if (nrst) begin
      r_fill_cnt  <= '0;
      r_shift_cnt <= '0;
      for (int i = 0; i < numIds; i++) begin
        r_act_buf[i] <= '0;
        r_wt_buf[i]  <= '0;
      end
    end else begin
      if ((r_state == S_ID_FILL) && id_valid_i) begin
        r_act_buf[r_fill_cnt] <= act_id_i;
        r_wt_buf[r_fill_cnt]  <= weight_id_i;
        r_fill_cnt <= (r_fill_cnt == ID_LAST) ? '0 : r_fill_cnt + ID_CNT_W'(1);
      end
      if (r_state == S_ID_SHIFT) r_shift_cnt <= r_shift_cnt + ID_CNT_W'(1);
      else                       r_shift_cnt <= '0;
    end
  end

  // Completion tracking: outs_valid count and sticky cluster_done since S_START
  always_ff @(posedge clk) begin
    if (nrst) begin
      r_out_cnt   <= '0;
      r_done_seen <= 1'b0;
    end else if ((r_state == S_START) || (r_state == S_COMPUTE)) begin
      r_done_seen <= w_done_seen_nxt;
      if (r_state == S_COMPUTE) r_out_cnt <= w_out_cnt_nxt;
    end else begin
      r_out_cnt   <= '0;
      r_done_seen <= 1'b0;
    end
  end

  stream_tag_forwarder #(
    .dataSize (dataSize),
    .idSize   (idSize),
    .addrSize (addrSize)
  ) u_w_fwd (
    .clk     (clk),
    .nrst    (nrst),
    .en_i    (r_state == S_LOAD_W),
    .num_i   (r_num_w),
    .valid_i (w_valid_i),
    .ready_o (w_ready_o),
    .data_i  (w_data_i),
    .tag_x_i (w_tag_x_i),
    .tag_y_i (w_tag_y_i),
    .data_o  (w_data_o),
    .tag_x_o (w_tag_x_o),
    .tag_y_o (w_tag_y_o),
    .last_o  (w_w_last)
  );

  stream_tag_forwarder #(
    .dataSize (dataSize),
    .idSize   (idSize),
    .addrSize (addrSize)
  ) u_a_fwd (
    .clk     (clk),
    .nrst    (nrst),
    .en_i    (r_state == S_LOAD_A),
    .num_i   (r_num_a),
    .valid_i (a_valid_i),
    .ready_o (a_ready_o),
    .data_i  (a_data_i),
    .tag_x_i (a_tag_x_i),
    .tag_y_i (a_tag_y_i),
    .data_o  (a_data_o),
    .tag_x_o (a_tag_x_o),
    .tag_y_o (a_tag_y_o),
    .last_o  (w_a_last)
  );

endmodule
